// File: rtl/both_edge_detector_if.sv
// Level-signal bundle for the dual-edge detector.
// The driver of a uses master; the detector uses slave.
interface both_edge_detector_if;
  logic a;
  logic exp_out;
  logic x1;

  modport master (output a, input exp_out, input x1);
  modport slave  (input a, output exp_out, output x1);
endinterface

// File: rtl/both_edge_detector.sv
// Dual-edge detector: flags any change of a against the previous sampled value.
// An optional N-flop synchronizer sits in front of the edge register.
module both_edge_detector #(
  parameter int SYNC_STAGES = 0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  both_edge_detector_if.slave bus
);

  logic a_s;
  logic x1_q;
  logic x1_d;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign a_s = bus.a;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      // Shift chain: stage 0 takes the raw input, each later stage takes its predecessor.
      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = bus.a;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // Synchronizer flops, cleared asynchronously.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
          sync_q <= sync_d;
        end
      end

      assign a_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign x1_d = a_s;

  // Edge register: holds the previous sample of the (synchronized) input.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x1_q <= 1'b0;
    end else begin
      x1_q <= x1_d;
    end
  end

  // The flag is deliberately unregistered so it rises in the same delta as the input.
  assign bus.exp_out = a_s ^ x1_q;
  assign bus.x1      = x1_q;

endmodule

// File: tb/tb_both_edge_detector.sv
// Directed self-checking bench for both_edge_detector (direct and 2-stage synchronized variants).
module tb_both_edge_detector;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulse_cnt;
  logic count_en;

  both_edge_detector_if bus0 ();
  both_edge_detector_if bus2 ();

  both_edge_detector #(.SYNC_STAGES(0)) dut0 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus0.slave)
  );

  both_edge_detector #(.SYNC_STAGES(2)) dut2 (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus2.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge bus0.exp_out) begin
    if (count_en) pulse_cnt = pulse_cnt + 1;
  end

  typedef struct {
    logic rst;
    logic a;
    logic flag;
    logic x1;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    count_en  = 1'b0;
    reset     = 1'b1;
    bus0.a    = 1'b0;
    bus2.a    = 1'b0;

    // Each vector is applied at a falling edge and checked 1 ns later.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0};

    #1;
    check("reset_flag", bus0.exp_out, 1'b0);
    check("reset_x1", bus0.x1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset  = vecs[i].rst;
      bus0.a = vecs[i].a;
      #1;
      check($sformatf("vec%0d_flag", i), bus0.exp_out, vecs[i].flag);
      check($sformatf("vec%0d_x1", i), bus0.x1, vecs[i].x1);
    end

    // Glitch between edges: flag follows it, edge register untouched.
    @(negedge clk);
    bus0.a = 1'b1;
    #1;
    check("glitch_hi_flag", bus0.exp_out, 1'b1);
    #2;
    bus0.a = 1'b0;
    #1;
    check("glitch_lo_flag", bus0.exp_out, 1'b0);
    check("glitch_lo_x1", bus0.x1, 1'b0);
    @(posedge clk);
    #1;
    check("glitch_after_edge_x1", bus0.x1, 1'b0);

    // a = 1,1,0,0,1,1,0,0 in 10 ns steps offset 5 ns from the clock edges.
    @(posedge clk);
    #5;
    count_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus0.a = (k % 4 < 2) ? 1'b1 : 1'b0;
      #10;
    end
    @(posedge clk);
    #1;
    count_en = 1'b0;
    check("seq_pulse_count", (pulse_cnt == 4) ? 1'b1 : 1'b0, 1'b1);
    if (pulse_cnt != 4) $display("  seq pulses seen %0d", pulse_cnt);
    check("seq_end_x1", bus0.x1, 1'b0);
    check("seq_end_flag", bus0.exp_out, 1'b0);

    // Two-stage synchronizer: flag appears after two rising edges, clears after the third.
    @(negedge clk);
    bus2.a = 1'b1;
    #1;
    check("sync_imm_flag", bus2.exp_out, 1'b0);
    @(posedge clk);
    #1;
    check("sync_e1_flag", bus2.exp_out, 1'b0);
    @(posedge clk);
    #1;
    check("sync_e2_flag", bus2.exp_out, 1'b1);
    check("sync_e2_x1", bus2.x1, 1'b0);
    @(posedge clk);
    #1;
    check("sync_e3_flag", bus2.exp_out, 1'b0);
    check("sync_e3_x1", bus2.x1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
